// File: rtl/l2_request_arbiter_if.sv
// Shared L2 request packet types and the bundle connecting L1 miss queues
// to the L2 request arbiter.
package l2_arb_pkg;
    localparam int CORE_ID_WIDTH   = 2;
    localparam int NUM_CORES       = 4;
    localparam int THREAD_ID_WIDTH = 2;

    typedef logic [CORE_ID_WIDTH-1:0] core_id_t;

    typedef enum logic [2:0] {
        L2REQ_LOAD,
        L2REQ_STORE,
        L2REQ_FLUSH,
        L2REQ_DINVALIDATE,
        L2REQ_LOAD_SYNC,
        L2REQ_STORE_SYNC
    } l2req_packet_type_t;

    typedef enum logic {
        CT_ICACHE,
        CT_DCACHE
    } cache_type_t;

    typedef struct packed {
        logic                       valid;
        core_id_t                   core;
        l2req_packet_type_t         packet_type;
        cache_type_t                cache_type;
        logic [THREAD_ID_WIDTH-1:0] id;
        logic [31:0]                address;
        logic [63:0]                store_mask;
        logic [511:0]               data;
    } l2req_packet_t;
endpackage

interface l2_request_arbiter_if #(
    parameter int NUM_REQUESTERS = l2_arb_pkg::NUM_CORES
) ();
    l2_arb_pkg::l2req_packet_t       core_request [NUM_REQUESTERS];
    logic [NUM_REQUESTERS-1:0]       core_ack;
    logic                            l2_stall;
    l2_arb_pkg::l2req_packet_t       l2_request;

    // master: the core/L2 environment; slave: the arbiter itself.
    modport master (
        output core_request,
        output l2_stall,
        input  core_ack,
        input  l2_request
    );

    modport slave (
        input  core_request,
        input  l2_stall,
        output core_ack,
        output l2_request
    );
endinterface

// File: rtl/l2_request_arbiter.sv
// Round-robin arbiter sharing the single L2 request port between the L1 miss
// queues; forwards one registered packet per cycle and holds it under stall.
module l2_request_arbiter
    import l2_arb_pkg::*;
#(
    parameter int NUM_REQUESTERS = NUM_CORES
) (
    input  logic                 clk,
    input  logic                 reset,
    l2_request_arbiter_if.slave  bus
);
    localparam int PTR_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

    l2req_packet_t             l2_request_q, l2_request_d;
    logic [PTR_W-1:0]          ptr_q, ptr_d;
    logic [NUM_REQUESTERS-1:0] req_valid;
    logic [NUM_REQUESTERS-1:0] grant_oh;
    logic [PTR_W:0]            cand;
    logic [PTR_W-1:0]          grant_idx;
    logic                      grant_found;
    logic                      can_accept;
    logic                      grant;

    for (genvar gi = 0; gi < NUM_REQUESTERS; gi++) begin : g_req
        assign req_valid[gi] = bus.core_request[gi].valid;
        assign grant_oh[gi]  = grant && (grant_idx == PTR_W'(gi));
    end

    assign can_accept = !l2_request_q.valid || !bus.l2_stall;
    // No ack may escape while reset is held, even though the output is empty.
    assign grant      = can_accept && grant_found && !reset;

    // First valid requester at or after the pointer, wrapping modulo N.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int off = 0; off < NUM_REQUESTERS; off++) begin
            cand = {1'b0, ptr_q} + (PTR_W+1)'(off);
            if (cand >= (PTR_W+1)'(NUM_REQUESTERS))
                cand = cand - (PTR_W+1)'(NUM_REQUESTERS);
            if (!grant_found && req_valid[cand[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        l2_request_d = l2_request_q;
        ptr_d        = ptr_q;
        if (grant) begin
            l2_request_d      = bus.core_request[grant_idx];
            l2_request_d.core = core_id_t'(grant_idx);
            ptr_d = (grant_idx == PTR_W'(NUM_REQUESTERS - 1)) ? '0 : grant_idx + 1'b1;
        end else if (can_accept) begin
            l2_request_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l2_request_q <= '0;
            ptr_q        <= '0;
        end else begin
            l2_request_q <= l2_request_d;
            ptr_q        <= ptr_d;
        end
    end

    assign bus.core_ack   = grant_oh;
    assign bus.l2_request = l2_request_q;
endmodule
